// File: rtl/upc_checkout_ctrl_pkg.sv
// Shared types and constants for the UPC checkout controller: state encoding,
// valid item-code list and the sale/theft decision rules.
package upc_pkg;

   localparam int CODE_W = 3;
   localparam int CNT_W  = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      SALE  = 3'd2,
      ALARM = 3'd3,
      ERROR = 3'd4
   } state_t;

   // Bit i set means item code i is a legal {U,P,C} combination (0,1,3,4,5,6).
   localparam logic [7:0] VALID_CODES = 8'b0111_1011;

   function automatic logic code_valid(input logic [CODE_W-1:0] code);
      return VALID_CODES[code];
   endfunction

   // item = {M,U,P,C}
   function automatic logic item_sale(input logic [CODE_W:0] item);
      return (item[2] & item[0]) | item[1];
   endfunction

   function automatic logic item_stolen(input logic [CODE_W:0] item);
      return ~item[1] & ~item[3] & (item[2] | ~item[0]);
   endfunction

endpackage

// File: rtl/upc_checkout_ctrl_if.sv
// Operator-panel bundle of the checkout controller: switch/button inputs and
// the registered LED, display and counter outputs.
interface upc_checkout_ctrl_if;
   import upc_pkg::*;

   logic [CODE_W-1:0] code;
   logic              mark;
   logic              scan;
   logic              ack;
   logic [CODE_W:0]   item_code;
   logic              sale_led;
   logic              alarm_led;
   logic              err_led;
   logic              busy;
   logic [CNT_W-1:0]  sale_cnt;
   logic [CNT_W-1:0]  theft_cnt;

   modport master (
      output code, mark, scan, ack,
      input  item_code, sale_led, alarm_led, err_led, busy, sale_cnt, theft_cnt
   );

   modport slave (
      input  code, mark, scan, ack,
      output item_code, sale_led, alarm_led, err_led, busy, sale_cnt, theft_cnt
   );

endinterface

// File: rtl/upc_checkout_ctrl_key_sync.sv
// Two-flop synchronizer for an asynchronous pushbutton with a one-cycle
// rising-edge pulse on the synchronized level.
module key_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic rise
);

   logic sync_p0, sync_p1, prev_p2;
   logic vld_p0, vld_p1;
   logic armed;

   // Stage p0/p1: metastability filter; p2: previous level for edge detect.
   // The valid bits mark when sync_p1 holds a real sample rather than the
   // reset value, so a button held through reset must be seen low before
   // any press counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         prev_p2 <= 1'b0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         armed   <= 1'b0;
      end else begin
         sync_p0 <= key;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
         vld_p0  <= 1'b1;
         vld_p1  <= vld_p0;
         armed   <= armed | (vld_p1 & ~sync_p1);
      end
   end

   assign rise = armed & sync_p1 & ~prev_p2;

endmodule

// File: rtl/upc_checkout_ctrl.sv
// Checkout controller: classifies a scanned {M,U,P,C} item as sale, theft
// alarm, illegal code or pass-through, drives the panel LEDs and counters.
module upc_checkout_ctrl
   import upc_pkg::*;
#(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int BLINK_HALF  = 12_500_000
) (
   input logic                clk,
   input logic                rst_n,
   upc_checkout_ctrl_if.slave bus
);

   localparam int TMR_MAX = (HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] BLINK_LAST = TMR_W'(BLINK_HALF - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic              scan_evt, ack_evt;
   logic [CODE_W:0]   item_p0, item_p1;

   state_t            state, state_nxt;
   logic [TMR_W-1:0]  timer, timer_nxt;
   logic [CODE_W:0]   item_q, item_nxt;
   logic              blink_q, blink_nxt;
   logic              sale_inc, theft_inc;
   logic              sale_q, err_q, busy_q;
   logic [CNT_W-1:0]  sale_cnt_q, theft_cnt_q;

   key_sync u_scan_sync (.clk(clk), .rst_n(rst_n), .key(bus.scan), .rise(scan_evt));
   key_sync u_ack_sync  (.clk(clk), .rst_n(rst_n), .key(bus.ack),  .rise(ack_evt));

   // Stage p0/p1: switch levels synchronized to the same depth as the scan edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         item_p0 <= '0;
         item_p1 <= '0;
      end else begin
         item_p0 <= {bus.mark, bus.code};
         item_p1 <= item_p0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer + 1'b1;
      item_nxt  = item_q;
      blink_nxt = blink_q;
      sale_inc  = 1'b0;
      theft_inc = 1'b0;
      case (state)
         IDLE: begin
            timer_nxt = '0;
            if (scan_evt) begin
               item_nxt  = item_p1;
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            timer_nxt = '0;
            if (!code_valid(item_q[CODE_W-1:0])) begin
               state_nxt = ERROR;
            end else if (item_sale(item_q)) begin
               state_nxt = SALE;
               sale_inc  = 1'b1;
            end else if (item_stolen(item_q)) begin
               state_nxt = ALARM;
               theft_inc = 1'b1;
               blink_nxt = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         SALE, ERROR: begin
            if (timer == HOLD_LAST) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end
         end
         ALARM: begin
            if (ack_evt) begin
               state_nxt = IDLE;
               timer_nxt = '0;
               blink_nxt = 1'b0;
            end else if (timer == BLINK_LAST) begin
               timer_nxt = '0;
               blink_nxt = ~blink_q;
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
            blink_nxt = 1'b0;
         end
      endcase
   end

   // Outputs are registered from the next state so LEDs change on the same
   // edge as the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         item_q      <= '0;
         blink_q     <= 1'b0;
         sale_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         sale_cnt_q  <= '0;
         theft_cnt_q <= '0;
      end else begin
         item_q  <= item_nxt;
         blink_q <= blink_nxt;
         sale_q  <= (state_nxt == SALE);
         err_q   <= (state_nxt == ERROR);
         busy_q  <= (state_nxt != IDLE);
         if (sale_inc)  sale_cnt_q  <= sat_inc(sale_cnt_q);
         if (theft_inc) theft_cnt_q <= sat_inc(theft_cnt_q);
      end
   end

   assign bus.item_code = item_q;
   assign bus.sale_led  = sale_q;
   assign bus.alarm_led = blink_q;
   assign bus.err_led   = err_q;
   assign bus.busy      = busy_q;
   assign bus.sale_cnt  = sale_cnt_q;
   assign bus.theft_cnt = theft_cnt_q;

endmodule
